alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked ALU. Operands and opcode are accepted with a valid/ready handshake. Logic and add-class operations complete in one cycle. Shifts and multiply run iteratively over several cycles. The result and four flags stay registered until the consumer takes them. It serves as the execution unit behind the lab CPU's decode stage, and it adds multi-cycle operations, carry chaining and backpressure that a purely combinational ALU cannot provide.

## Interface
- WIDTH, 8, operand/result width; must be ≥ 2
- SHW, $clog2(WIDTH), shift-amount width, derived, not to be overridden
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept; high only in IDLE
- op  in  4  opcode (below)
- A, B  in  WIDTH  operands; for shifts the amount is B[SHW-1:0]
- out_valid  out  1  F/flags valid
- out_ready  in  1  consumer takes result
- F  out  WIDTH  result
- cf, zero, of, neg  out  1  carry/borrow, F==0, signed overflow, F[WIDTH-1]

## Operation
- Opcodes:
  - 0 ADD: {cf,F}=A+B; of = same operand signs and sign of F differs.
  - 1 SUB: {cf,F}=A−B; cf=borrow, i.e. A<B unsigned; of = operand signs differ and sign of F ≠ sign of A.
  - 2 NOT A.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SGT: F=1 if signed A>B, else 0.
  - 7 EQ: F=1 if A==B, else 0.
  - 8 ADC: {cf,F}=A+B+cf. The current registered cf is the carry-in. of as ADD.
  - 9 SLL.
  - 10 SRL.
  - 11 SRA.
  - 12 MUL: F=low WIDTH bits of unsigned A×B; of=1 if the high half ≠ 0; cf=0.
  - 13–15: F=0, cf=of=0.
- Ops 2–7 and 13–15 force cf=of=0. zero and neg are always derived from the final F.
- Shifts move one bit per cycle over B[SHW-1:0] iterations. cf = last bit shifted out, or 0 if the amount is 0. of=0. SRA replicates the MSB.
- MUL is shift-add, one multiplier bit per cycle, WIDTH iterations, using a 2·WIDTH accumulator.
- State machine:
  - IDLE: in_ready=1. On in_valid, latch op/A/B.
    - Single-cycle op, or shift by 0 → DONE with result registered.
    - Otherwise → BUSY with counter loaded.
  - BUSY: iterate; counter reaches 0 → DONE.
  - DONE: out_valid=1. Outputs are held until out_ready. On out_ready → IDLE.
- No overlap: a new operation is accepted only in IDLE, so a result must be drained first. in_valid outside IDLE is ignored.
- cf/of/F/zero/neg update only on the transition into DONE. They hold their values through IDLE and BUSY, so ADC can chain off the previous op.
- Reset: state=IDLE, F=0, cf=of=neg=0, zero=1, out_valid=0, in_ready=1.
- Reset asserted mid-BUSY or in DONE aborts immediately. The pending result is lost.

## Timing
- Accept at edge n (in_valid & in_ready):
  - Single-cycle op: out_valid high after edge n+1. Latency 1.
  - Shift by k>0: out_valid after edge n+k+1.
  - MUL: out_valid after edge n+WIDTH+1.
- DONE with out_ready high at edge m → IDLE after m. The earliest next accept is edge m+1, so peak throughput is one op per 2 cycles.
- in_ready and out_valid are decoded from registered state only. There are no combinational paths from in_valid or out_ready to any output.

## Structure
- Package alu_seq_pkg:
  - opcode localparams OP_ADD…OP_MUL
  - state enum IDLE/BUSY/DONE
- Sub-module alu_seq_comb: purely combinational single-cycle datapath (ops 0–8, 13–15) producing F/cf/of. The top keeps the FSM, iteration counter, shift/multiply registers and output registers.

## Test plan
All scenarios use WIDTH=8.
- ADD 0x7F+0x01 → F=0x80, of=1, cf=0, neg=1, zero=0; out_valid one cycle after accept.
- SUB 0x00−0x01 → F=0xFF, cf=1. Then ADC 0x10+0x20 → F=0x31, cf=0.
- MUL 0x10×0x10 → F=0x00, zero=1, of=1; out_valid 9 cycles after accept. MUL 0x0F×0x0F → F=0xE1, of=0.
- SRA 0x80 by 3 → F=0xF0, cf=0, 4-cycle latency. SLL 0x81 by 1 → F=0x02, cf=1. SRL by 0 → F=A, cf=0, 1-cycle latency.
- Hold out_ready=0 for 5 cycles in DONE with in_valid pulsing → F/flags stable, in_ready=0, no new op latched. Release → IDLE, next accept one cycle later.
- Assert rst during the 4th cycle of MUL → outputs go immediately to F=0, zero=1, out_valid=0, in_ready=1. After release, ADD 0x02+0x03 → F=0x05.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Package for alu_seq: opcode encodings, FSM state type and opcode helpers.
// No ports; imported by alu_seq_comb and alu_seq.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SGT = 4'd6;
    localparam logic [3:0] OP_EQ  = 4'd7;
    localparam logic [3:0] OP_ADC = 4'd8;
    localparam logic [3:0] OP_SLL = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Handshake bundle between an ALU client (master) and alu_seq (slave).
//   in_valid/in_ready/op/A/B   : operation request channel
//   out_valid/out_ready/F/flags: result channel (cf, zero, of, neg)
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] F;
    logic             cf;
    logic             zero;
    logic             of;
    logic             neg;

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, F, cf, zero, of, neg
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, F, cf, zero, of, neg
    );
endinterface

// File: rtl/alu_seq_comb.sv
// Combinational single-cycle datapath of alu_seq (ops 0-8 and 13-15).
//   i_op  : opcode         i_a, i_b : operands     i_cin : carry-in for ADC
//   o_f   : result         o_cf     : carry/borrow o_of  : signed overflow
// Iterative opcodes (SLL/SRL/SRA/MUL) yield zeros here; the top handles them.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_f,
    output logic             o_cf,
    output logic             o_of
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_adc;
    logic [WIDTH:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_adc  = w_sum + {{WIDTH{1'b0}}, i_cin};
    // Extra MSB of the zero-extended difference is the unsigned borrow.
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_f  = '0;
        o_cf = 1'b0;
        o_of = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_f  = w_sum[MSB:0];
                o_cf = w_sum[WIDTH];
                o_of = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
            end
            OP_SUB: begin
                o_f  = w_diff[MSB:0];
                o_cf = w_diff[WIDTH];
                o_of = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
            end
            OP_NOT: o_f = ~i_a;
            OP_AND: o_f = i_a & i_b;
            OP_OR:  o_f = i_a | i_b;
            OP_XOR: o_f = i_a ^ i_b;
            OP_SGT: o_f = {{(WIDTH-1){1'b0}}, ($signed(i_a) > $signed(i_b))};
            OP_EQ:  o_f = {{(WIDTH-1){1'b0}}, (i_a == i_b)};
            OP_ADC: begin
                o_f  = w_adc[MSB:0];
                o_cf = w_adc[WIDTH];
                o_of = (i_a[MSB] == i_b[MSB]) && (w_adc[MSB] != i_a[MSB]);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle logic/add ops and iterative
// shifts (one bit per cycle) and shift-add multiply (WIDTH cycles).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : alu_seq_if slave port (request channel, result channel, flags)
// Result and flags are registered and held until out_ready; they only change
// when entering DONE, so ADC can chain off the previous operation's cf.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_sh;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_f;
    logic               r_cf;
    logic               r_of;
    logic               r_zero;
    logic               r_neg;

    logic               w_accept;
    logic               w_multi;
    logic               w_amt_zero;
    logic               w_last;
    logic [SHW-1:0]     w_amt;
    logic [WIDTH-1:0]   w_sh_next;
    logic               w_sh_out;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_comb_f;
    logic               w_comb_cf;
    logic               w_comb_of;
    logic               w_load;
    logic [WIDTH-1:0]   w_res_f;
    logic               w_res_cf;
    logic               w_res_of;

    assign w_accept   = (r_state == IDLE) && bus.in_valid;
    assign w_amt      = bus.B[SHW-1:0];
    assign w_multi    = is_shift(bus.op) || (bus.op == OP_MUL);
    assign w_amt_zero = is_shift(bus.op) && (w_amt == '0);
    // The final iteration is folded into the edge that enters DONE, so the
    // counter reaches zero on that same edge.
    assign w_last     = (r_state == BUSY) && (r_cnt == CW'(1));

    alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
        .i_op  (bus.op),
        .i_a   (bus.A),
        .i_b   (bus.B),
        .i_cin (r_cf),
        .o_f   (w_comb_f),
        .o_cf  (w_comb_cf),
        .o_of  (w_comb_of)
    );

    always_comb begin
        w_sh_next = r_sh;
        w_sh_out  = 1'b0;
        case (r_op)
            OP_SLL: begin
                w_sh_next = {r_sh[WIDTH-2:0], 1'b0};
                w_sh_out  = r_sh[WIDTH-1];
            end
            OP_SRL: begin
                w_sh_next = {1'b0, r_sh[WIDTH-1:1]};
                w_sh_out  = r_sh[0];
            end
            OP_SRA: begin
                w_sh_next = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
                w_sh_out  = r_sh[0];
            end
            default: ;
        endcase
    end

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_load   = 1'b0;
        w_res_f  = w_comb_f;
        w_res_cf = w_comb_cf;
        w_res_of = w_comb_of;
        if (w_accept && !w_multi) begin
            w_load = 1'b1;
        end else if (w_accept && w_amt_zero) begin
            w_load   = 1'b1;
            w_res_f  = bus.A;
            w_res_cf = 1'b0;
            w_res_of = 1'b0;
        end else if (w_last) begin
            w_load = 1'b1;
            if (r_op == OP_MUL) begin
                w_res_f  = w_acc_next[WIDTH-1:0];
                w_res_cf = 1'b0;
                w_res_of = |w_acc_next[2*WIDTH-1:WIDTH];
            end else begin
                w_res_f  = w_sh_next;
                w_res_cf = w_sh_out;
                w_res_of = 1'b0;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_next = (w_multi && !w_amt_zero) ? BUSY : DONE;
            BUSY:    if (r_cnt == CW'(1)) w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_sh     <= '0;
            r_mplier <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_f      <= '0;
            r_cf     <= 1'b0;
            r_of     <= 1'b0;
            r_zero   <= 1'b1;
            r_neg    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= bus.op;
                r_sh     <= bus.A;
                r_mplier <= bus.B;
                r_mcand  <= {{WIDTH{1'b0}}, bus.A};
                r_acc    <= '0;
                r_cnt    <= (bus.op == OP_MUL) ? CW'(WIDTH) : CW'(w_amt);
            end else if (r_state == BUSY) begin
                r_sh     <= w_sh_next;
                r_mplier <= r_mplier >> 1;
                r_mcand  <= r_mcand << 1;
                r_acc    <= w_acc_next;
                r_cnt    <= r_cnt - CW'(1);
            end
            if (w_load) begin
                r_f    <= w_res_f;
                r_cf   <= w_res_cf;
                r_of   <= w_res_of;
                r_zero <= (w_res_f == '0);
                r_neg  <= w_res_f[WIDTH-1];
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.F         = r_f;
    assign bus.cf        = r_cf;
    assign bus.of        = r_of;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): vector table through a
// scoreboard, plus hand-written backpressure and mid-operation reset cases.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string        name;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] f;
        logic         cf;
        logic         of;
        int           lat;
    } vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] f;
        logic         cf;
        logic         of;
        logic         zero;
        logic         neg;
        int           lat;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] f, input logic cf,
                          input logic of, input int lat);
        exp_t e;
        int   n;
        @(negedge clk);
        check({name, ".in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.A = a;
        bus.B = b;
        e.name = name;
        e.f = f;
        e.cf = cf;
        e.of = of;
        e.zero = (f == '0);
        e.neg = f[W-1];
        e.lat = lat;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check({name, ".out_valid"}, bus.out_valid, 1);
        if (!bus.out_valid) begin
            sb.delete();
            return;
        end
        e = sb.pop_front();
        check({e.name, ".latency"}, n, e.lat);
        check({e.name, ".F"}, bus.F, e.f);
        check({e.name, ".cf"}, bus.cf, e.cf);
        check({e.name, ".of"}, bus.of, e.of);
        check({e.name, ".zero"}, bus.zero, e.zero);
        check({e.name, ".neg"}, bus.neg, e.neg);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    initial begin
        // Order matters: ADC rows depend on the cf left by the row before.
        vt.push_back('{"add_ovf",   OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1});
        vt.push_back('{"sub_brw",   OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1});
        vt.push_back('{"adc_chain", OP_ADC, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0, 1});
        vt.push_back('{"mul_ovf",   OP_MUL, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 9});
        vt.push_back('{"mul_fit",   OP_MUL, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 9});
        vt.push_back('{"sra3",      OP_SRA, 8'h80, 8'h03, 8'hF0, 1'b0, 1'b0, 4});
        vt.push_back('{"sll1",      OP_SLL, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 2});
        vt.push_back('{"srl0",      OP_SRL, 8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0, 1});
        vt.push_back('{"not",       OP_NOT, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1});
        vt.push_back('{"and",       OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1});
        vt.push_back('{"or",        OP_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1});
        vt.push_back('{"xor",       OP_XOR, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0, 1});
        vt.push_back('{"sgt_t",     OP_SGT, 8'h01, 8'hFF, 8'h01, 1'b0, 1'b0, 1});
        vt.push_back('{"sgt_f",     OP_SGT, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 1});
        vt.push_back('{"eq",        OP_EQ,  8'h5A, 8'h5A, 8'h01, 1'b0, 1'b0, 1});
        vt.push_back('{"op14",      4'd14,  8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1});
        vt.push_back('{"srl7",      OP_SRL, 8'hC1, 8'h07, 8'h01, 1'b1, 1'b0, 8});
        vt.push_back('{"sll_bhi",   OP_SLL, 8'h01, 8'h0A, 8'h04, 1'b0, 1'b0, 3});
        vt.push_back('{"sub_ovf",   OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1});
        vt.push_back('{"add_cy",    OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1});
        vt.push_back('{"adc_ovf",   OP_ADC, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b1, 1});

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = '0;
        bus.A = '0;
        bus.B = '0;
        repeat (2) @(negedge clk);
        check("rst.F", bus.F, 0);
        check("rst.zero", bus.zero, 1);
        check("rst.cf", bus.cf, 0);
        check("rst.of", bus.of, 0);
        check("rst.neg", bus.neg, 0);
        check("rst.out_valid", bus.out_valid, 0);
        check("rst.in_ready", bus.in_ready, 1);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++)
            run_op(vt[i].name, vt[i].op, vt[i].a, vt[i].b, vt[i].f, vt[i].cf, vt[i].of, vt[i].lat);

        // Backpressure: result held for 5 cycles while in_valid pulses.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = OP_ADD;
        bus.A = 8'h11;
        bus.B = 8'h22;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("bp.out_valid0", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = (i % 2 == 0);
            bus.op = OP_SUB;
            bus.A = 8'h99;
            bus.B = 8'h01;
            @(posedge clk);
            #1;
            check("bp.F", bus.F, 8'h33);
            check("bp.out_valid", bus.out_valid, 1);
            check("bp.in_ready", bus.in_ready, 0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check("bp.rel_in_ready", bus.in_ready, 1);
        check("bp.rel_out_valid", bus.out_valid, 0);
        bus.in_valid = 1'b1;
        bus.op = OP_XOR;
        bus.A = 8'h0F;
        bus.B = 8'h01;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("bp.next_out_valid", bus.out_valid, 1);
        check("bp.next_F", bus.F, 8'h0E);
        check("bp.next_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;

        // Reset during the 4th busy cycle of a multiply.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = OP_MUL;
        bus.A = 8'h10;
        bus.B = 8'h10;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("mrst.busy_in_ready", bus.in_ready, 0);
        check("mrst.busy_out_valid", bus.out_valid, 0);
        rst = 1'b1;
        #1;
        check("mrst.F", bus.F, 0);
        check("mrst.zero", bus.zero, 1);
        check("mrst.out_valid", bus.out_valid, 0);
        check("mrst.in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst_add", OP_ADD, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
